// File: rtl/hex_text_overlay_if.sv
// hex_text_overlay host write port.
// The host (master) writes hex digits into the overlay buffer (slave).
interface hex_text_overlay_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [3:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/hex_text_overlay.sv
// hex_text_overlay: hex digit grid overlay driven by the 5x7 font engine.
// Define HEX_OVL_SHADOW_EN for a shadow buffer committed on vsync rise.
module hex_text_overlay #(
  parameter int          ROWS   = 4,
  parameter int          COLS   = 16,
  parameter int          COL0   = 2,
  parameter int          ROW0   = 2,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blank,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [6:0]        char_x,
  input  logic [6:0]        char_y,
  input  logic [15:0]       char_data,
  hex_text_overlay_if.slave wr,
  output logic [11:0]       vga_rgb,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank
);

  localparam int N = ROWS * COLS;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0] NCELL = 7'(N);
  localparam logic [6:0] ROWS7 = 7'(ROWS);
  localparam logic [6:0] COLS7 = 7'(COLS);
  localparam logic [6:0] ROW07 = 7'(ROW0);
  localparam logic [6:0] COL07 = 7'(COL0);

  typedef struct packed {
    logic [6:0] cx;
    logic [6:0] cy;
    logic       blank;
    logic       hs;
    logic       vs;
  } s1_t;

  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } s2_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        blank;
    logic        hs;
    logic        vs;
  } out_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  out_t out_d, out_q;

  logic [3:0] disp_d [N];
  logic [3:0] disp_q [N];

  logic            wr_hit;
  logic [IDXW-1:0] wa;

  logic [6:0]      row;
  logic [6:0]      col;
  logic            in_win;
  logic [IDXW-1:0] idx;
  logic [3:0]      digit;
  logic            lit;

  assign wr_hit = wr.wr_en && ({1'b0, wr.wr_addr} < NCELL);
  assign wa     = wr.wr_addr[IDXW-1:0];

`ifdef HEX_OVL_SHADOW_EN
  logic [3:0] shad_d [N];
  logic [3:0] shad_q [N];
  logic       commit;

  // s1_q.vs is vsync one cycle ago, so this fires once per rising edge
  assign commit = vsync && !s1_q.vs;

  // Host writes land in shad; disp takes the pre-write shad at commit
  always_comb begin
    shad_d = shad_q;
    disp_d = disp_q;
    if (commit) disp_d = shad_q;
    if (wr_hit) shad_d[wa] = wr.wr_data;
  end

  // Shadow buffer storage
  always_ff @(posedge clk) begin
    if (reset) shad_q <= '{default: '0};
    else       shad_q <= shad_d;
  end
`else
  // Host writes go straight to the displayed buffer
  always_comb begin
    disp_d = disp_q;
    if (wr_hit) disp_d[wa] = wr.wr_data;
  end
`endif

  // Displayed digit storage
  always_ff @(posedge clk) begin
    if (reset) disp_q <= '{default: '0};
    else       disp_q <= disp_d;
  end

  // Stage 1: align coordinates with the engine, delay raw timing once
  always_comb begin
    s1_d.cx    = char_x;
    s1_d.cy    = char_y;
    s1_d.blank = blank;
    s1_d.hs    = hsync;
    s1_d.vs    = vsync;
  end

  // Stage 2 timing: coordinates are consumed combinationally here
  always_comb begin
    s2_d.blank = s1_q.blank;
    s2_d.hs    = s1_q.hs;
    s2_d.vs    = s1_q.vs;
  end

  // Window test wraps below origin; digit lookup and glyph bit select
  always_comb begin
    row    = s1_q.cy - ROW07;
    col    = s1_q.cx - COL07;
    in_win = (col < COLS7) && (row < ROWS7);
    idx    = IDXW'(row) * IDXW'(COLS) + IDXW'(col);
    digit  = in_win ? disp_q[idx] : 4'd0;
    lit    = char_data[digit];
  end

  // Stage 3: pixel colour with timing registered in parallel
  always_comb begin
    out_d.blank = s2_q.blank;
    out_d.hs    = s2_q.hs;
    out_d.vs    = s2_q.vs;
    out_d.rgb   = 12'h000;
    if (!s2_q.blank && in_win)
      out_d.rgb = lit ? FG_RGB : BG_RGB;
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign vga_rgb   = out_q.rgb;
  assign vga_hs    = out_q.hs;
  assign vga_vs    = out_q.vs;
  assign vga_blank = out_q.blank;

endmodule

// File: tb/tb_hex_text_overlay.sv
// Directed bench for hex_text_overlay (default and shadow builds).
// A second instance with ROWS=2 covers out-of-range writes.
module tb_hex_text_overlay;

  localparam logic [11:0] FG = 12'hABC;
  localparam logic [11:0] BG = 12'h123;

  logic        clk = 1'b0;
  logic        reset;
  logic        blank, hsync, vsync;
  logic [6:0]  char_x, char_y;
  logic [15:0] char_data;
  logic [11:0] vga_rgb, vga_rgb2;
  logic        vga_hs, vga_vs, vga_blank;
  logic        vga_hs2, vga_vs2, vga_blank2;

  int nchecks = 0;
  int nerrors = 0;

  hex_text_overlay_if wif ();

  hex_text_overlay #(
    .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .clk(clk), .reset(reset),
    .blank(blank), .hsync(hsync), .vsync(vsync),
    .char_x(char_x), .char_y(char_y), .char_data(char_data),
    .wr(wif),
    .vga_rgb(vga_rgb), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank(vga_blank)
  );

  hex_text_overlay #(
    .ROWS(2), .FG_RGB(FG), .BG_RGB(BG)
  ) dut2 (
    .clk(clk), .reset(reset),
    .blank(blank), .hsync(hsync), .vsync(vsync),
    .char_x(char_x), .char_y(char_y), .char_data(char_data),
    .wr(wif),
    .vga_rgb(vga_rgb2), .vga_hs(vga_hs2),
    .vga_vs(vga_vs2), .vga_blank(vga_blank2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] d);
    wif.wr_en   = 1'b1;
    wif.wr_addr = a;
    wif.wr_data = d;
    step();
    wif.wr_en   = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
  endtask

  task automatic pix(input string tag, input logic [6:0] x,
                     input logic [6:0] y, input logic [15:0] d,
                     input logic [11:0] exp);
    char_x    = x;
    char_y    = y;
    char_data = d;
    repeat (4) step();
    check(tag, {20'd0, vga_rgb}, {20'd0, exp});
  endtask

  initial begin
    reset       = 1'b1;
    blank       = 1'b1;
    hsync       = 1'b1;
    vsync       = 1'b1;
    char_x      = 7'd2;
    char_y      = 7'd2;
    char_data   = 16'hFFFF;
    wif.wr_en   = 1'b0;
    wif.wr_addr = '0;
    wif.wr_data = '0;
    repeat (3) step();
    check("rst_rgb", {20'd0, vga_rgb}, 32'h0);
    check("rst_hs", {31'd0, vga_hs}, 32'h0);
    check("rst_vs", {31'd0, vga_vs}, 32'h0);
    check("rst_blank", {31'd0, vga_blank}, 32'h0);

    reset = 1'b0;
    blank = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    step();

    // cleared buffer renders digit 0
    pix("win0_lit", 7'd2, 7'd2, 16'h0001, FG);
    pix("win0_unlit", 7'd2, 7'd2, 16'hFFFE, BG);
    pix("last_cell", 7'd17, 7'd5, 16'h0001, FG);
    pix("left_out", 7'd1, 7'd2, 16'hFFFF, 12'h000);
    pix("right_out", 7'd18, 7'd2, 16'hFFFF, 12'h000);
    pix("above_out", 7'd2, 7'd1, 16'hFFFF, 12'h000);
    pix("below_out", 7'd2, 7'd6, 16'hFFFF, 12'h000);
    blank = 1'b1;
    pix("blank_win", 7'd2, 7'd2, 16'hFFFF, 12'h000);

    // sync and blank latency: sample at E1 shows after E3
    hsync = 1'b1;
    blank = 1'b0;
    step();
    check("hs_e1", {31'd0, vga_hs}, 32'h0);
    check("rgb_e1", {20'd0, vga_rgb}, 32'h0);
    step();
    hsync = 1'b0;
    check("hs_e2", {31'd0, vga_hs}, 32'h0);
    check("rgb_e2", {20'd0, vga_rgb}, 32'h0);
    check("blank_e2", {31'd0, vga_blank}, 32'h1);
    step();
    check("hs_e3", {31'd0, vga_hs}, 32'h1);
    check("rgb_e3", {20'd0, vga_rgb}, {20'd0, FG});
    check("blank_e3", {31'd0, vga_blank}, 32'h0);
    step();
    check("hs_e4", {31'd0, vga_hs}, 32'h1);
    step();
    check("hs_e5", {31'd0, vga_hs}, 32'h0);

    vsync = 1'b1;
    repeat (2) step();
    check("vs_e2", {31'd0, vga_vs}, 32'h0);
    step();
    check("vs_e3", {31'd0, vga_vs}, 32'h1);
    vsync = 1'b0;
    repeat (4) step();

    // digit A at cell 0, glyph bit 10
    wr(6'd0, 4'hA);
`ifdef HEX_OVL_SHADOW_EN
    pix("shad_old0", 7'd2, 7'd2, 16'h0001, FG);
    pix("shad_oldA", 7'd2, 7'd2, 16'h0400, BG);
    vs_pulse();
`endif
    pix("wr_A", 7'd2, 7'd2, 16'h0400, FG);
    pix("wr_A_not0", 7'd2, 7'd2, 16'h0001, BG);

    // last cell and out-of-range for the 2-row instance
    wr(6'd63, 4'hC);
    wr(6'd40, 4'hF);
    vs_pulse();
    pix("wr63", 7'd17, 7'd5, 16'h1000, FG);
    pix("wr40", 7'd10, 7'd4, 16'h8000, FG);
    check("r2_cell8", {20'd0, vga_rgb2}, 32'h0);
    pix("r2_cell8_0", 7'd10, 7'd2, 16'h0001, 12'h000 | FG);
    check("r2_cell8_q", {20'd0, vga_rgb2}, {20'd0, FG});
    pix("r2_out", 7'd10, 7'd4, 16'hFFFF, FG);
    check("r2_row2", {20'd0, vga_rgb2}, 32'h0);

    // write coincident with the vsync rising edge
    vsync       = 1'b1;
    wif.wr_en   = 1'b1;
    wif.wr_addr = 6'd5;
    wif.wr_data = 4'h7;
    step();
    wif.wr_en = 1'b0;
    repeat (3) step();
    vsync = 1'b0;
    step();
`ifdef HEX_OVL_SHADOW_EN
    pix("coinc_old", 7'd7, 7'd2, 16'h0080, BG);
`else
    pix("coinc_new", 7'd7, 7'd2, 16'h0080, FG);
`endif
    vs_pulse();
    pix("coinc_after", 7'd7, 7'd2, 16'h0080, FG);

    // reset mid-line clears outputs and buffers
    hsync = 1'b1;
    pix("pre_rst", 7'd2, 7'd2, 16'h0400, FG);
    check("pre_rst_hs", {31'd0, vga_hs}, 32'h1);
    reset = 1'b1;
    step();
    check("mid_rst_rgb", {20'd0, vga_rgb}, 32'h0);
    check("mid_rst_hs", {31'd0, vga_hs}, 32'h0);
    reset = 1'b0;
    hsync = 1'b0;
    pix("post_rst_A", 7'd2, 7'd2, 16'h0400, BG);
    pix("post_rst_0", 7'd2, 7'd2, 16'h0001, FG);
    pix("post_rst_63", 7'd17, 7'd5, 16'h1000, BG);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/hex_text_overlay.md
# hex_text_overlay

Pixel-stage consumer of the 5x7 hex font engine. Holds a ROWS x COLS grid of 4-bit hex digits written by a host port, maps the font engine's character coordinates onto that grid, and selects the matching glyph bit from the engine's 16-bit per-glyph pixel vector. Outputs a registered RGB pixel plus delay-matched sync and blank for the VGA output pins.

## Interface
- ROWS, 4, number of text rows in the window
- COLS, 16, hex digits per row
- COL0, 2, first character column of the window (char_x units)
- ROW0, 2, first character row of the window (char_y units)
- FG_RGB, 12'hFFF, colour for a lit glyph pixel
- BG_RGB, 12'h000, colour for an unlit pixel inside the window
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- blank  in  1  raw blanking; same signal driven to the font engine
- hsync  in  1  raw hsync; same signal driven to the font engine
- vsync  in  1  raw vsync; same signal driven to the font engine
- char_x  in  7  font engine character column (registered, 1 cycle after timing)
- char_y  in  7  font engine character row (same alignment as char_x)
- char_data  in  16  font engine glyph bits, bit n = glyph n lit (2 cycles after timing)
- wr_en  in  1  write strobe for the digit buffer
- wr_addr  in  6  digit index = row*COLS + col
- wr_data  in  4  hex digit value
- vga_rgb  out  12  pixel colour {R4,G4,B4}
- vga_hs  out  1  hsync delayed 3 cycles
- vga_vs  out  1  vsync delayed 3 cycles
- vga_blank  out  1  blank delayed 3 cycles

## Operation
- Digit storage: display buffer disp[ROWS*COLS] of 4 bits; with shadow option also shad[ROWS*COLS].
- Write: wr_en=1 and wr_addr < ROWS*COLS writes wr_data to the write target (shad or disp, see Configuration). wr_addr >= ROWS*COLS ignored, no side effects.
- Commit: vsync rising edge detected as vsync & !vsync_d1 (vsync_d1 reset 0). On that cycle disp <= shad for all entries.
- Write and commit in the same cycle: shad takes the new digit; disp receives the pre-write shad contents; new digit appears after the next vsync edge.
- Stage 1 (t+1): register char_x, char_y into cx1, cy1; delay blank/hsync/vsync one stage.
- Stage 2 (t+2): cx1/cy1 now aligned with char_data. in_win = (cx1-COL0) < COLS and (cy1-ROW0) < ROWS, computed unsigned at 7 bits so coordinates below origin wrap and fail. digit = disp[(cy1-ROW0)*COLS + (cx1-COL0)]; lit = char_data[digit].
- Stage 3 (t+3): vga_rgb <= blank_d2 ? 0 : !in_win ? 0 : lit ? FG_RGB : BG_RGB. Delayed syncs registered in parallel.
- Column padding (sixth column, top row of each 6x8 cell) comes from glyph zeros; no extra gating.

## Timing
- Total latency 3 cycles: timing sample at cycle t is displayed on all outputs at t+3; vga_hs/vs/blank stay exactly aligned with vga_rgb.
- Reset: vga_rgb=0, vga_hs=0, vga_vs=0, vga_blank=0, all pipeline regs 0, disp and shad all 0 (window shows '0' digits).
- Reset mid-frame: outputs 0 on the cycle after reset asserts; pipeline refills in 3 cycles after deassertion; buffers cleared, pending writes lost.
- Write to visible: with shadow, first frame after the next vsync rising edge; without, the next stage-2 read of that entry (can change mid-frame).
- vsync held high over many cycles: exactly one commit per rising edge.

## Configuration
- HEX_OVL_SHADOW_EN defined: shad buffer present, writes target shad, disp updated only at vsync rising edge (tear-free).
- Undefined: no shad buffer, no commit logic; writes go directly to disp, visible immediately.

## Test plan
- Reset, run one frame -> every window cell renders '0' in FG_RGB/BG_RGB, pixels outside window and during blank are 12'h000.
- Drive blank low, hsync pulse at cycle t -> vga_hs pulse at t+3 same width; first visible pixel colour at t+3 relative to its blank sample.
- Shadow on: write addr 0 = 4'hA mid-frame -> cell (ROW0,COL0) still '0' this frame, shows 'A' after next vsync rise; shadow off -> 'A' within same frame.
- wr_addr = 6'd63 with ROWS=4, COLS=16 writes last cell; ROWS=2 and wr_addr=40 -> ignored, buffer unchanged.
- wr_en coincident with vsync rising edge, wr_addr 5 = 4'h7 -> cell 5 unchanged this frame, '7' after the following vsync rise.
- char_x = COL0-1 and COL0+COLS, char_y = ROW0-1 -> vga_rgb 0 at those pixels; assert reset mid-line -> outputs 0 next cycle, cells read '0' after.
